pe_stream_ctrl: RTL and testbench



---
 rtl/pe_stream_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pe_stream_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_stream_ctrl.sv
// rtl/pe_stream_ctrl.sv - operand sequencer and credit-controlled result collector for one PE MAC unit
module pe_stream_ctrl #(
  parameter int para_int_bits  = 7,
  parameter int para_frac_bits = 9,
  parameter int VEC_LEN        = 16,
  parameter int FIFO_DEPTH     = 8,
  localparam int W             = para_int_bits + para_frac_bits
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic [W-1:0] pe_data_in_1,
  output logic [W-1:0] pe_data_in_2,
  output logic [3:0]   pe_add_number,
  output logic         pe_rounder_en,
  output logic         pe_keep,
  input  logic [W-1:0] pe_data_out,
  input  logic         pe_rounder_valid,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [2:0]   out_acc,
  output logic         busy,
  output logic         ovf_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0]   LAST_ELEM = 16'(VEC_LEN - 1);
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);

  logic [15:0]   elem_cnt_q, elem_cnt_d;
  logic [2:0]    acc_idx_q, acc_idx_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [2:0]    inflight_q, inflight_d;
  logic [W-1:0]  pe_a_q, pe_a_d, pe_b_q, pe_b_d;
  logic [2:0]    pe_acc_q, pe_acc_d;
  logic          pe_round_q, pe_round_d;
  logic [W+2:0]  mem_q [FIFO_DEPTH];
  logic [W+2:0]  mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    wr_tag_q, wr_tag_d;
  logic          ovf_q, ovf_d;

  logic last_elem, accept, wrap, fifo_empty, fifo_full, pop, push, strobe_dec;
  logic [W+2:0] head;

  // A vector's final element is held back only when no FIFO slot is reserved for its result.
  assign last_elem  = (elem_cnt_q == LAST_ELEM);
  assign in_ready   = !rst && !(last_elem && (credit_q == '0));
  assign accept     = in_valid && in_ready;
  assign wrap       = accept && last_elem;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_CNT);
  assign pop        = !fifo_empty && out_ready;
  // A pop frees the slot the strobe needs, so a full FIFO still takes the write.
  assign push       = pe_rounder_valid && (!fifo_full || pop);
  assign strobe_dec = pe_rounder_valid && (inflight_q != '0);

  assign head          = mem_q[rd_ptr_q];
  assign out_valid     = !fifo_empty;
  assign out_data      = head[W-1:0];
  assign out_acc       = head[W+2:W];
  assign busy          = (inflight_q != '0) || out_valid;
  assign ovf_err       = ovf_q;
  assign pe_data_in_1  = pe_a_q;
  assign pe_data_in_2  = pe_b_q;
  assign pe_add_number = {1'b0, pe_acc_q};
  assign pe_rounder_en = pe_round_q;
  assign pe_keep       = 1'b0;

  // Operand sequencing: bubbles feed a zero product so the accumulator holds its value.
  always_comb begin
    pe_a_d     = accept ? in_a : '0;
    pe_b_d     = accept ? in_b : '0;
    pe_acc_d   = acc_idx_q;
    pe_round_d = wrap;
    elem_cnt_d = elem_cnt_q;
    acc_idx_d  = acc_idx_q;
    if (accept) elem_cnt_d = last_elem ? '0 : elem_cnt_q + 16'd1;
    if (wrap)   acc_idx_d  = acc_idx_q + 3'd1;
  end

  // Credit and in-flight bookkeeping; simultaneous increment and decrement cancel.
  always_comb begin
    credit_d = credit_q;
    unique case ({wrap, pop})
      2'b10:   credit_d = credit_q - CW'(1);
      2'b01:   credit_d = credit_q + CW'(1);
      default: credit_d = credit_q;
    endcase
    inflight_d = inflight_q;
    unique case ({wrap, strobe_dec})
      2'b10:   inflight_d = inflight_q + 3'd1;
      2'b01:   inflight_d = inflight_q - 3'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  // Result FIFO: tagged writes from the PE strobe, head popped by the downstream handshake.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    wr_tag_d = wr_tag_q;
    count_d  = count_q;
    ovf_d    = ovf_q || (pe_rounder_valid && !push);
    if (push) begin
      mem_d[wr_ptr_q] = {wr_tag_q, pe_data_out};
      wr_ptr_d        = wr_ptr_q + PW'(1);
      wr_tag_d        = wr_tag_q + 3'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; reset empties the FIFO with every entry cleared to {0, 0}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem_cnt_q <= '0;
      acc_idx_q  <= '0;
      credit_q   <= DEPTH_CNT;
      inflight_q <= '0;
      pe_a_q     <= '0;
      pe_b_q     <= '0;
      pe_acc_q   <= '0;
      pe_round_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wr_tag_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      elem_cnt_q <= elem_cnt_d;
      acc_idx_q  <= acc_idx_d;
      credit_q   <= credit_d;
      inflight_q <= inflight_d;
      pe_a_q     <= pe_a_d;
      pe_b_q     <= pe_b_d;
      pe_acc_q   <= pe_acc_d;
      pe_round_q <= pe_round_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      wr_tag_q   <= wr_tag_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pe_stream_ctrl.sv
// tb/tb_pe_stream_ctrl.sv - self-checking bench for pe_stream_ctrl with a behavioural PE and dot-product reference
module tb_pe_stream_ctrl;
  localparam int IB = 7;
  localparam int FB = 9;
  localparam int W  = IB + FB;
  localparam int VL = 4;
  localparam int FD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_a, in_b, pe_data_in_1, pe_data_in_2, pe_data_out, out_data;
  logic [3:0]   pe_add_number;
  logic         pe_rounder_en, pe_keep, pe_rounder_valid, busy, ovf_err;
  logic [2:0]   out_acc;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rr_viol = 0;
  int round_cyc [8];

  longint ref_sum;
  int ref_n, ref_vec;
  logic [W+2:0] exp_q[$];
  logic [W+2:0] obs_q[$];

  pe_stream_ctrl #(.para_int_bits(IB), .para_frac_bits(FB), .VEC_LEN(VL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .pe_data_in_1(pe_data_in_1), .pe_data_in_2(pe_data_in_2), .pe_add_number(pe_add_number),
    .pe_rounder_en(pe_rounder_en), .pe_keep(pe_keep), .pe_data_out(pe_data_out),
    .pe_rounder_valid(pe_rounder_valid), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_acc(out_acc), .busy(busy), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  function automatic longint prod(input logic [W-1:0] a, input logic [W-1:0] b);
    return longint'($signed(a)) * longint'($signed(b));
  endfunction

  function automatic logic [W-1:0] round_fx(input longint s);
    longint r;
    r = (s + (longint'(1) <<< (FB - 1))) >>> FB;
    return r[W-1:0];
  endfunction

  // Behavioural PE: eight accumulators, result strobed three cycles after the round request.
  longint       pe_acc [8];
  logic [W-1:0] pipe_d [3];
  logic         pipe_v [3];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) pe_acc[i] <= 0;
      for (int i = 0; i < 3; i++) begin pipe_v[i] <= 1'b0; pipe_d[i] <= '0; end
    end else begin
      if (pe_rounder_en) begin
        pipe_d[0] <= round_fx(pe_acc[pe_add_number[2:0]] + prod(pe_data_in_1, pe_data_in_2));
        pe_acc[pe_add_number[2:0]] <= 0;
      end else begin
        pe_acc[pe_add_number[2:0]] <= pe_acc[pe_add_number[2:0]] + prod(pe_data_in_1, pe_data_in_2);
      end
      pipe_v[0] <= pe_rounder_en;
      pipe_v[1] <= pipe_v[0];
      pipe_v[2] <= pipe_v[1];
      pipe_d[1] <= pipe_d[0];
      pipe_d[2] <= pipe_d[1];
    end
  end
  assign pe_data_out      = pipe_d[2];
  assign pe_rounder_valid = pipe_v[2];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: collect popped results and watch for an accumulator re-targeted right after its round.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) round_cyc[i] <= -100;
    end else begin
      if (out_valid && out_ready) obs_q.push_back({out_acc, out_data});
      if ((cyc - round_cyc[pe_add_number[2:0]]) inside {[1:3]}) rr_viol <= rr_viol + 1;
      if (pe_rounder_en) round_cyc[pe_add_number[2:0]] <= cyc;
    end
  end

  task automatic ref_clear();
    ref_sum = 0; ref_n = 0; ref_vec = 0;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic ref_accept(input logic [W-1:0] a, input logic [W-1:0] b);
    ref_sum += prod(a, b);
    ref_n++;
    if (ref_n == VL) begin
      exp_q.push_back({3'(ref_vec % 8), round_fx(ref_sum)});
      ref_vec++; ref_n = 0; ref_sum = 0;
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, output logic acc);
    in_valid = v; in_a = a; in_b = b;
    @(negedge clk);
    acc = v && in_ready && !rst;
    if (acc) ref_accept(a, b);
    @(posedge clk); #1;
  endtask

  task automatic drain(input int bound, output logic ok);
    in_valid = 1'b0; out_ready = 1'b1; ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!busy && !out_valid) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    ref_clear();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({pe_data_in_1, pe_data_in_2, pe_add_number, pe_rounder_en, pe_keep} !== '0) begin
      n_errors++; $display("FAIL reset_pe_outputs: got %h %h %h %b %b required all 0", pe_data_in_1, pe_data_in_2, pe_add_number, pe_rounder_en, pe_keep);
    end
    n_checks++;
    if ({out_valid, out_data, out_acc, busy, ovf_err, in_ready} !== '0) begin
      n_errors++; $display("FAIL reset_outputs: got valid=%b data=%h acc=%0d busy=%b ovf=%b rdy=%b required all 0", out_valid, out_data, out_acc, busy, ovf_err, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_release_ready: got %b required 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic acc, ok; int n, kc, first;
    out_ready = 1'b1; n = 0; first = -1;
    for (int i = 0; i < VL; i++) begin drive(1'b1, 16'h0200, 16'h0200, acc); if (acc) n++; end
    kc = cyc; in_valid = 1'b0;
    n_checks++;
    if (n != VL) begin n_errors++; $display("FAIL single_accepts: got %0d required %0d", n, VL); end
    n_checks++;
    if ({pe_rounder_en, pe_add_number, busy} !== {1'b1, 4'd0, 1'b1}) begin
      n_errors++; $display("FAIL single_round_req: got en=%b idx=%0d busy=%b required 1 0 1", pe_rounder_en, pe_add_number, busy);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin first = cyc; break; end
    end
    n_checks++;
    if (first != kc + 4) begin n_errors++; $display("FAIL single_latency: out_valid at cycle %0d required %0d", first, kc + 4); end
    n_checks++;
    if ({out_acc, out_data} !== {3'd0, 16'h0800}) begin
      n_errors++; $display("FAIL single_value: got acc=%0d data=%h required acc=0 data=0800", out_acc, out_data);
    end
    @(posedge clk); #1;
    drain(200, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL single_drain: timed out required idle"); end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL single_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL single_result[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_round_robin();
    logic acc, ok; int n, viol0;
    out_ready = 1'b1; n = 0; viol0 = rr_viol;
    for (int i = 0; i < 9 * VL; i++) begin drive(1'b1, 16'h0200, 16'h0100, acc); if (acc) n++; end
    drain(200, ok);
    n_checks++;
    if (!ok || n != 9 * VL) begin n_errors++; $display("FAIL rr_accepts: got %0d idle=%b required %0d idle=1", n, ok, 9 * VL); end
    n_checks++;
    if (rr_viol != viol0) begin n_errors++; $display("FAIL rr_retarget: got %0d violations required 0", rr_viol - viol0); end
    n_checks++;
    if (obs_q.size() != 9 || exp_q.size() != 9) begin n_errors++; $display("FAIL rr_count: got %0d required 9", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i] || obs_q[i][W-1:0] !== 16'h0400) begin
        n_errors++; $display("FAIL rr_result[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_bubbles();
    logic acc, ok;
    logic [7:0] pattern;
    pattern = 8'b10101001;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(pattern[i], 16'h0200, 16'h0200, acc);
      if (!pattern[i]) begin
        n_checks++;
        if ({pe_data_in_1, pe_data_in_2, pe_rounder_en} !== '0) begin
          n_errors++; $display("FAIL bubble_zero[%0d]: got %h %h en=%b required 0 0 0", i, pe_data_in_1, pe_data_in_2, pe_rounder_en);
        end
      end
    end
    drain(200, ok);
    n_checks++;
    if (!ok || obs_q.size() != 1 || exp_q.size() != 1) begin n_errors++; $display("FAIL bubble_count: got %0d idle=%b required 1 idle=1", obs_q.size(), ok); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i] || obs_q[i][W-1:0] !== 16'h0800) begin n_errors++; $display("FAIL bubble_result: got %h required %h", obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic acc, ok; int n;
    out_ready = 1'b0; n = 0;
    for (int i = 0; i < 30; i++) begin drive(1'b1, W'($urandom), W'($urandom), acc); if (acc) n++; end
    n_checks++;
    if (n != FD * VL + VL - 1) begin n_errors++; $display("FAIL bp_accepts: got %0d required %0d", n, FD * VL + VL - 1); end
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, ovf_err} !== 3'b010) begin
      n_errors++; $display("FAIL bp_stalled: got rdy=%b valid=%b ovf=%b required 0 1 0", in_ready, out_valid, ovf_err);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(1'b1, W'($urandom), W'($urandom), acc);
    n_checks++;
    if (acc !== 1'b0) begin n_errors++; $display("FAIL bp_blocked_during_pop: got %b required 0", acc); end
    out_ready = 1'b0;
    drive(1'b1, W'($urandom), W'($urandom), acc);
    n_checks++;
    if (acc !== 1'b1) begin n_errors++; $display("FAIL bp_accept_after_pop: got %b required 1", acc); end
    in_valid = 1'b0;
    repeat (8) @(posedge clk); #1;
    n_checks++;
    if (ovf_err !== 1'b0) begin n_errors++; $display("FAIL bp_ovf: got %b required 0", ovf_err); end
    drain(200, ok);
    n_checks++;
    if (!ok || obs_q.size() != exp_q.size() || exp_q.size() != FD + 1) begin
      n_errors++; $display("FAIL bp_count: got %0d idle=%b required %0d", obs_q.size(), ok, FD + 1);
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL bp_result[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_pop_with_final();
    logic acc, ok;
    out_ready = 1'b0;
    for (int i = 0; i < (FD - 1) * VL; i++) drive(1'b1, 16'h0200, 16'h0100, acc);
    in_valid = 1'b0;
    repeat (8) @(posedge clk); #1;
    for (int e = 0; e < VL - 1; e++) drive(1'b1, 16'h0200, 16'h0100, acc);
    out_ready = 1'b1;
    drive(1'b1, 16'h0200, 16'h0100, acc);
    out_ready = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (acc !== 1'b1) begin n_errors++; $display("FAIL pf_final_with_pop: got %b required 1", acc); end
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL pf_ready_after: got %b required 1", in_ready); end
    @(posedge clk); #1;
    for (int e = 0; e < VL; e++) drive(1'b1, 16'h0300, 16'h0100, acc);
    n_checks++;
    if (acc !== 1'b1) begin n_errors++; $display("FAIL pf_credit_kept: got %b required 1", acc); end
    for (int e = 0; e < VL; e++) drive(1'b1, 16'h0100, 16'h0100, acc);
    n_checks++;
    if (acc !== 1'b0) begin n_errors++; $display("FAIL pf_credit_exhausted: got %b required 0", acc); end
    drain(200, ok);
    n_checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL pf_count: got %0d idle=%b required %0d", obs_q.size(), ok, exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL pf_result[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic acc, ok;
    for (int i = 0; i < 400; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      drive($urandom_range(0, 3) != 0, W'($urandom), W'($urandom), acc);
    end
    drain(300, ok);
    n_checks++;
    if (!ok || ovf_err !== 1'b0) begin n_errors++; $display("FAIL rand_idle: got idle=%b ovf=%b required 1 0", ok, ovf_err); end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL rand_count: got %0d required %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL rand_result[%0d]: got %h required %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic acc, ok;
    out_ready = 1'b1;
    for (int i = 0; i < 2 * VL; i++) begin
      drive(1'b1, 16'h0200, 16'h0200, acc);
      if (acc && ref_n == 0) break;
    end
    drive(1'b1, 16'h0200, 16'h0200, acc);
    drive(1'b1, 16'h0200, 16'h0200, acc);
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL rm_busy_before: got %b required 1", busy); end
    rst = 1'b1; in_valid = 1'b0;
    ref_clear();
    #1;
    n_checks++;
    if ({pe_data_in_1, pe_data_in_2, pe_add_number, pe_rounder_en, pe_keep} !== '0) begin
      n_errors++; $display("FAIL rm_pe_outputs: got %h %h %h %b %b required all 0", pe_data_in_1, pe_data_in_2, pe_add_number, pe_rounder_en, pe_keep);
    end
    n_checks++;
    if ({out_valid, out_data, out_acc, busy, ovf_err, in_ready} !== '0) begin
      n_errors++; $display("FAIL rm_outputs: got valid=%b data=%h acc=%0d busy=%b ovf=%b rdy=%b required all 0", out_valid, out_data, out_acc, busy, ovf_err, in_ready);
    end
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rm_release_ready: got %b required 1", in_ready); end
    @(posedge clk); #1;
    for (int e = 0; e < VL; e++) drive(1'b1, 16'h0200, 16'h0200, acc);
    drain(200, ok);
    n_checks++;
    if (!ok || obs_q.size() != 1 || exp_q.size() != 1) begin n_errors++; $display("FAIL rm_count: got %0d idle=%b required 1 idle=1", obs_q.size(), ok); end
    if (obs_q.size() > 0) begin
      n_checks++;
      if (obs_q[0] !== {3'd0, 16'h0800}) begin n_errors++; $display("FAIL rm_result: got %h required %h", obs_q[0], {3'd0, 16'h0800}); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_bubbles();
    test_backpressure();
    test_pop_with_final();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
